// File: rtl/mul_seq.sv
// mul_seq: radix-2 shift-add multiplier with valid/ready handshakes.
// Produces the low W bits of i_a * i_b after a fixed W-cycle iteration.
module mul_seq #(
    parameter int W      = 64,
    parameter bit SIGNED = 1'b1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_p
);

    localparam int  CW        = $clog2(W);
    localparam bit  W_OK      = (W == 8) || (W == 16) || (W == 32) || (W == 64);
    // Low product bits are sign-agnostic; SIGNED is only sanity-checked here.
    localparam bit  SIGNED_OK = (SIGNED == 1'b0) || (SIGNED == 1'b1);

    if (!W_OK || !SIGNED_OK) begin : g_bad_param
        $error("mul_seq: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t        state;
    logic [W-1:0]  mc;
    logic [W-1:0]  mp;
    logic [W-1:0]  acc;
    logic [W-1:0]  acc_add;
    logic [CW-1:0] cnt;

    always_comb begin
        acc_add = acc;
        if (mp[0]) begin
            acc_add = acc + mc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            o_ready <= 1'b1;
            o_valid <= 1'b0;
            o_p     <= '0;
            mc      <= '0;
            mp      <= '0;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        mc      <= i_a;
                        mp      <= i_b;
                        acc     <= '0;
                        cnt     <= CW'(W - 1);
                        o_ready <= 1'b0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    acc <= acc_add;
                    mc  <= mc << 1;
                    mp  <= mp >> 1;
                    // Final iteration: publish the sum including this step.
                    if (cnt == '0) begin
                        o_p     <= acc_add;
                        o_valid <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        o_valid <= 1'b0;
                        o_ready <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_seq.sv
// tb_mul_seq: scoreboard bench for mul_seq at W = 8, 16, 32, 64.
// Instance d has width 8 << d.
module tb_mul_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst   [4];
    logic        valid [4];
    logic        rdy   [4];
    logic        ovld  [4];
    logic        irdy  [4];
    logic [63:0] a     [4];
    logic [63:0] b     [4];
    logic [63:0] p     [4];

    int tests = 0;
    int fails = 0;
    int cyc_n = 0;
    int acc_cyc [4];
    logic [63:0] sbq [4][$];

    always @(posedge clk) cyc_n++;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int GW = 8 << g;
        logic [GW-1:0] pp;
        mul_seq #(
            .W      (GW),
            .SIGNED (1'b1)
        ) u_dut (
            .i_clk   (clk),
            .i_rst   (rst[g]),
            .i_valid (valid[g]),
            .o_ready (rdy[g]),
            .i_a     (a[g][GW-1:0]),
            .i_b     (b[g][GW-1:0]),
            .o_valid (ovld[g]),
            .i_ready (irdy[g]),
            .o_p     (pp)
        );
        assign p[g] = 64'(pp);
    end

    function automatic logic [63:0] msk(int d);
        logic [63:0] one = 64'd1;
        if (d == 3) return '1;
        return (one << (8 << d)) - 64'd1;
    endfunction

    function automatic logic [63:0] ref_mul(int d, logic [63:0] x, logic [63:0] y);
        return (x * y) & msk(d);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int d, logic [63:0] x, logic [63:0] y);
        int n = 0;
        a[d] = x;
        b[d] = y;
        valid[d] = 1'b1;
        while (!rdy[d] && n < 500) begin
            tick();
            n++;
        end
        if (!rdy[d]) begin
            tests++;
            fails++;
            $display("FAIL send_timeout dut%0d: o_ready=0, required 1", d);
            valid[d] = 1'b0;
            return;
        end
        tick();
        valid[d] = 1'b0;
        acc_cyc[d] = cyc_n;
        sbq[d].push_back(ref_mul(d, x, y));
    endtask

    task automatic recv(int d, string nm, output int lat);
        int n = 0;
        logic [63:0] exp;
        lat = -1;
        irdy[d] = 1'b1;
        while (!ovld[d] && n < 500) begin
            tick();
            n++;
        end
        tests++;
        if (!ovld[d]) begin
            fails++;
            $display("FAIL %s: o_valid=0 after timeout, required 1", nm);
            return;
        end
        lat = cyc_n - acc_cyc[d];
        if (sbq[d].size() == 0) begin
            fails++;
            $display("FAIL %s: unexpected result %h, required none", nm, p[d]);
        end else begin
            exp = sbq[d].pop_front();
            if (p[d] !== exp) begin
                fails++;
                $display("FAIL %s: o_p=%h, required %h", nm, p[d], exp);
            end
        end
        tick();
    endtask

    task automatic test_reset();
        for (int d = 0; d < 4; d++) begin
            rst[d] = 1'b1;
            valid[d] = 1'b0;
            irdy[d] = 1'b0;
            a[d] = '0;
            b[d] = '0;
        end
        tick();
        tick();
        for (int d = 0; d < 4; d++) begin
            rst[d] = 1'b0;
            tests++;
            if (rdy[d] !== 1'b1 || ovld[d] !== 1'b0 || p[d] !== 64'd0) begin
                fails++;
                $display("FAIL reset dut%0d: rdy=%b vld=%b p=%h, required 1 0 0",
                         d, rdy[d], ovld[d], p[d]);
            end
        end
    endtask

    task automatic test_basic();
        int lat;
        send(0, 64'd7, 64'd9);
        recv(0, "basic", lat);
        tests++;
        if (lat !== 8) begin
            fails++;
            $display("FAIL basic_latency: %0d, required 8", lat);
        end
        tests++;
        if (p[0] !== 64'h3F || ovld[0] !== 1'b0 || rdy[0] !== 1'b1) begin
            fails++;
            $display("FAIL basic_after: p=%h vld=%b rdy=%b, required 3f 0 1",
                     p[0], ovld[0], rdy[0]);
        end
    endtask

    task automatic test_wrap();
        logic [63:0] xs [3] = '{64'hFF, 64'd16, 64'h80};
        logic [63:0] ys [3] = '{64'hFF, 64'd16, 64'h02};
        logic [63:0] ls [3] = '{64'h01, 64'h00, 64'h00};
        int lat;
        for (int i = 0; i < 3; i++) begin
            send(0, xs[i], ys[i]);
            recv(0, "wrap", lat);
            tests++;
            if (p[0] !== ls[i] || lat !== 8) begin
                fails++;
                $display("FAIL wrap%0d: p=%h lat=%0d, required %h 8",
                         i, p[0], lat, ls[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int n = 0;
        irdy[1] = 1'b0;
        send(1, 64'd300, 64'd200);
        while (!ovld[1] && n < 100) begin
            tick();
            n++;
        end
        a[1] = 64'd1;
        b[1] = 64'd1;
        valid[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tests++;
            if (ovld[1] !== 1'b1 || p[1] !== 64'hEA60 || rdy[1] !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d: vld=%b p=%h rdy=%b, required 1 ea60 0",
                         i, ovld[1], p[1], rdy[1]);
            end
            tick();
        end
        recv(1, "bp_result", lat);
        tests++;
        if (rdy[1] !== 1'b1 || ovld[1] !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: rdy=%b vld=%b, required 1 0", rdy[1], ovld[1]);
        end
        tick();
        acc_cyc[1] = cyc_n;
        sbq[1].push_back(ref_mul(1, 64'd1, 64'd1));
        valid[1] = 1'b0;
        tests++;
        if (rdy[1] !== 1'b0) begin
            fails++;
            $display("FAIL bp_accept: rdy=%b, required 0", rdy[1]);
        end
        recv(1, "bp_next", lat);
        tests++;
        if (lat !== 16 || p[1] !== 64'd1) begin
            fails++;
            $display("FAIL bp_next_chk: lat=%0d p=%h, required 16 1", lat, p[1]);
        end
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (ovld[1]) n++;
            tick();
        end
        tests++;
        if (n !== 0 || sbq[1].size() !== 0) begin
            fails++;
            $display("FAIL bp_dup: extra valids=%0d, required 0", n);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int seen = 0;
        send(2, 64'd5, 64'd7);
        recv(2, "rm_pre", lat);
        send(2, 64'h1234, 64'h10);
        repeat (9) tick();
        rst[2] = 1'b1;
        tick();
        rst[2] = 1'b0;
        sbq[2].delete();
        tests++;
        if (ovld[2] !== 1'b0 || rdy[2] !== 1'b1 || p[2] !== 64'd0) begin
            fails++;
            $display("FAIL rm_reset: vld=%b rdy=%b p=%h, required 0 1 0",
                     ovld[2], rdy[2], p[2]);
        end
        for (int i = 0; i < 40; i++) begin
            if (ovld[2]) seen++;
            tick();
        end
        tests++;
        if (seen !== 0) begin
            fails++;
            $display("FAIL rm_lost: valids=%0d, required 0", seen);
        end
        send(2, 64'd3, 64'hFFFF_FFFB);
        recv(2, "rm_fresh", lat);
        tests++;
        if (p[2] !== 64'hFFFF_FFF1 || lat !== 32) begin
            fails++;
            $display("FAIL rm_fresh_chk: p=%h lat=%0d, required fffffff1 32", p[2], lat);
        end
    endtask

    task automatic test_identity();
        int lat;
        send(3, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        recv(3, "id_zero", lat);
        tests++;
        if (lat !== 64 || p[3] !== 64'd0) begin
            fails++;
            $display("FAIL id_zero_chk: lat=%0d p=%h, required 64 0", lat, p[3]);
        end
        send(3, 64'h8000_0000_0000_0001, 64'd1);
        recv(3, "id_one", lat);
        tests++;
        if (lat !== 64 || p[3] !== 64'h8000_0000_0000_0001) begin
            fails++;
            $display("FAIL id_one_chk: lat=%0d p=%h, required 64 8000000000000001",
                     lat, p[3]);
        end
    endtask

    task automatic stream(int d, int n);
        fork
            begin : drv
                for (int i = 0; i < n; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    send(d, {$urandom, $urandom}, {$urandom, $urandom});
                end
            end
            begin : mon
                int got = 0;
                int budget = 0;
                logic [63:0] exp;
                while (got < n && budget < 40000) begin
                    irdy[d] = ($urandom_range(0, 3) != 0);
                    if (ovld[d] && irdy[d]) begin
                        got++;
                        tests++;
                        if (sbq[d].size() == 0) begin
                            fails++;
                            $display("FAIL rand dut%0d: extra result %h", d, p[d]);
                        end else begin
                            exp = sbq[d].pop_front();
                            if (p[d] !== exp) begin
                                fails++;
                                $display("FAIL rand dut%0d #%0d: o_p=%h, required %h",
                                         d, got, p[d], exp);
                            end
                        end
                    end
                    tick();
                    budget++;
                end
                if (got < n) begin
                    tests++;
                    fails++;
                    $display("FAIL rand_timeout dut%0d: got %0d, required %0d", d, got, n);
                end
            end
        join
    endtask

    task automatic test_random();
        fork
            stream(0, 1000);
            stream(3, 300);
        join
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_identity();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
